// File: rtl/sdfirm_apb_slave.sv
// sdfirm_apb_slave: APB register slave with programmable wait states.
//   Register map (byte offset from BASE_ADDR):
//     0x00 ID (RO), 0x04 STATUS (RO, {err_cnt, wr_cnt}), 0x08.. scratch (RW).
//   Ports:
//     pclk, preset     clock, async active-high reset
//     psel, penable    APB phase controls
//     pwrite, paddr,   transfer direction / byte address / write data
//     pwdata
//     pready, prdata,  completion, read data and error response; the data
//     pslverr          and error outputs are non-zero only while pready=1
module sdfirm_apb_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h5344_4150
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_e;

  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [31:0] SPAN    = 32'(4 * NUM_REGS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        write_q;
  logic [31:0] regs_q [16];
  logic [15:0] wr_cnt_q, err_cnt_q;
  logic [15:0] wr_cnt_d, err_cnt_d;

  logic        setup, access, capture, done;
  logic [31:0] off;
  logic [3:0]  idx;
  logic        hit, err;
  logic [31:0] rd_val;

  assign setup   = psel & ~penable;
  assign access  = psel & penable;
  assign capture = (state_q == S_IDLE) & setup;
  // Completion needs the access phase still held; a dropped psel/penable in
  // READY is an abort and commits nothing.
  assign done    = (state_q == S_READY) & access;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = S_READY;
          end
        end
      end
      S_WAIT: begin
        if (!access)            state_d = S_IDLE;
        else if (cnt_q == 4'd0) state_d = S_READY;
        else                    cnt_d   = cnt_q - 4'd1;
      end
      S_READY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    pready  = done;
    pslverr = done & err;
    prdata  = (done && !err && !write_q) ? rd_val : 32'h0;
  end

  // ---------------- address decode on latched request ----------------
  // addr_q >= BASE_ADDR guarantees the subtraction does not wrap.
  assign off = addr_q - BASE_ADDR;
  assign idx = off[5:2];
  assign hit = (addr_q >= BASE_ADDR) && (off < SPAN) && (addr_q[1:0] == 2'b00);
  assign err = ~hit | (write_q & (idx < 4'd2));

  always_comb begin
    case (idx)
      4'd0:    rd_val = ID_VALUE;
      4'd1:    rd_val = {err_cnt_q, wr_cnt_q};
      default: rd_val = regs_q[idx];
    endcase
  end

  // ---------------- request latch ----------------
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      write_q <= 1'b0;
    end else if (capture) begin
      addr_q  <= paddr;
      wdata_q <= pwdata;
      write_q <= pwrite;
    end
  end

  // ---------------- scratch registers ----------------
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= 32'h0;
    end else if (done && !err && write_q) begin
      for (int i = 2; i < NUM_REGS; i++)
        if (idx == 4'(i)) regs_q[i] <= wdata_q;
    end
  end

  // ---------------- saturating status counters ----------------
  assign wr_cnt_d  = (done && !err && write_q && wr_cnt_q != 16'hFFFF) ?
                     wr_cnt_q + 16'd1 : wr_cnt_q;
  assign err_cnt_d = (done && err && err_cnt_q != 16'hFFFF) ?
                     err_cnt_q + 16'd1 : err_cnt_q;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wr_cnt_q  <= 16'h0;
      err_cnt_q <= 16'h0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_sdfirm_apb_slave.sv
// Scoreboard bench: dut1 (WAIT_STATES=1, BASE 0) and dut0 (WAIT_STATES=0,
// BASE 0x4000_0100). Stimulus pushes expected responses; a negedge monitor
// pops one per pready and compares.
module tb_sdfirm_apb_slave;

  localparam logic [31:0] ID = 32'h5344_4150;
  localparam logic [31:0] B0 = 32'h4000_0100;

  logic              pclk = 1'b0;
  logic [1:0]        preset;
  logic [1:0]        psel, penable, pwrite, pready, pslverr;
  logic [1:0][31:0]  paddr, pwdata, prdata;

  typedef struct { logic [31:0] rd; logic err; int id; } exp_t;
  exp_t q0[$], q1[$];

  int total = 0, bad = 0, xid = 0, cyc = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;

  sdfirm_apb_slave #(.BASE_ADDR(B0), .NUM_REGS(8), .WAIT_STATES(0), .ID_VALUE(ID)) dut0 (
    .pclk(pclk), .preset(preset[0]), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
    .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]));

  sdfirm_apb_slave #(.BASE_ADDR(32'h0), .NUM_REGS(8), .WAIT_STATES(1), .ID_VALUE(ID)) dut1 (
    .pclk(pclk), .preset(preset[1]), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
    .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int k);
    exp_t e;
    total++;
    if (pready[k]) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        bad++;
        $display("FAIL stray_pready dut%0d at cycle %0d", k, cyc);
      end else begin
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (prdata[k] !== e.rd || pslverr[k] !== e.err) begin
          bad++;
          $display("FAIL xfer%0d dut%0d: got rd=%h err=%b want rd=%h err=%b",
                   e.id, k, prdata[k], pslverr[k], e.rd, e.err);
        end
      end
    end else if (prdata[k] !== 32'h0 || pslverr[k] !== 1'b0) begin
      bad++;
      $display("FAIL idle_outputs dut%0d cycle %0d: got rd=%h err=%b want 0/0",
               k, cyc, prdata[k], pslverr[k]);
    end
  endtask

  always @(negedge pclk) begin
    mon(0);
    mon(1);
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1; returns at posedge+1 after the READY cycle so that
  // consecutive calls are back-to-back. Access phase scrambles paddr/pwdata
  // to show the latched values are the ones used.
  task automatic xfer(input int k, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd,
                      input logic exp_err, output int done_cyc);
    exp_t e;
    int   lat;
    e.rd = exp_rd; e.err = exp_err; e.id = xid; xid++;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = a; pwdata[k] = d;
    @(posedge pclk); #1;
    penable[k] = 1'b1; paddr[k] = a ^ 32'h4; pwdata[k] = ~d;
    lat = 1;
    @(negedge pclk);
    while (!pready[k] && lat < 40) begin
      @(negedge pclk);
      lat++;
    end
    done_cyc = cyc;
    chk($sformatf("latency_xfer%0d", e.id), 32'(lat), (k == 1) ? 32'd2 : 32'd1);
    @(posedge pclk); #1;
    psel[k] = 1'b0; penable[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  int dc, c1, c2;

  initial begin
    preset = 2'b11; psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge pclk);
    #2;
    chk("reset_pready", {30'h0, pready}, 32'h0);
    chk("reset_pslverr", {30'h0, pslverr}, 32'h0);
    chk("reset_prdata1", prdata[1], 32'h0);
    @(posedge pclk); #1;
    preset = 2'b00;
    idle(1);

    // ---- dut1: WAIT_STATES=1 ----
    xfer(1, 0, 32'h00, 0, ID, 0, dc);
    xfer(1, 1, 32'h08, 32'hDEAD_BEEF, 0, 0, dc);
    xfer(1, 0, 32'h08, 0, 32'hDEAD_BEEF, 0, dc);
    xfer(1, 0, 32'h04, 0, 32'h0000_0001, 0, dc);
    xfer(1, 1, 32'h00, 32'h1, 0, 1, dc);
    xfer(1, 0, 32'h40, 0, 0, 1, dc);
    xfer(1, 0, 32'h0A, 0, 0, 1, dc);
    xfer(1, 1, 32'h04, 32'hFFFF_FFFF, 0, 1, dc);
    xfer(1, 0, 32'h04, 0, 32'h0004_0001, 0, dc);
    xfer(1, 0, 32'h00, 0, ID, 0, dc);
    xfer(1, 1, 32'h1C, 32'hA5A5_5A5A, 0, 0, dc);
    xfer(1, 0, 32'h1C, 0, 32'hA5A5_5A5A, 0, dc);
    xfer(1, 0, 32'h20, 0, 0, 1, dc);

    // abort in WAIT: setup then drop psel; no completion, no write
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h18; pwdata[1] = 32'h77;
    @(posedge pclk); #1;
    psel[1] = 1'b0;
    idle(3);
    xfer(1, 0, 32'h18, 0, 0, 0, dc);
    xfer(1, 0, 32'h04, 0, 32'h0005_0002, 0, dc);

    // reset pulsed during WAIT of a write to 0x14
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h14; pwdata[1] = 32'h55;
    @(posedge pclk); #1;
    penable[1] = 1'b1;
    #2 preset[1] = 1'b1;
    #1;
    chk("rst_mid_pready", {31'h0, pready[1]}, 32'h0);
    chk("rst_mid_prdata", prdata[1], 32'h0);
    @(posedge pclk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0; preset[1] = 1'b0;
    idle(1);
    xfer(1, 0, 32'h14, 0, 32'h0, 0, dc);
    xfer(1, 0, 32'h04, 0, 32'h0, 0, dc);
    xfer(1, 0, 32'h08, 0, 32'h0, 0, dc);
    xfer(1, 0, 32'h00, 0, ID, 0, dc);

    // ---- dut0: WAIT_STATES=0, non-zero base ----
    xfer(0, 1, B0 + 32'h0C, 32'h1, 0, 0, c1);
    xfer(0, 1, B0 + 32'h10, 32'h2, 0, 0, c2);
    chk("b2b_spacing", 32'(c2 - c1), 32'd2);
    xfer(0, 0, B0 + 32'h0C, 0, 32'h1, 0, dc);
    xfer(0, 0, B0 + 32'h10, 0, 32'h2, 0, dc);
    xfer(0, 0, 32'h4000_00FC, 0, 0, 1, dc);
    xfer(0, 0, B0, 0, ID, 0, dc);
    xfer(0, 0, B0 + 32'h04, 0, 32'h0001_0002, 0, dc);

    // Preload the write count as if 0xFFFD writes had already completed.
    force dut0.wr_cnt_d = 16'hFFFD;
    @(posedge pclk); #1;
    release dut0.wr_cnt_d;
    xfer(0, 1, B0 + 32'h08, 32'h101, 0, 0, dc);
    xfer(0, 1, B0 + 32'h08, 32'h102, 0, 0, dc);
    xfer(0, 1, B0 + 32'h08, 32'h103, 0, 0, dc);
    xfer(0, 0, B0 + 32'h04, 0, 32'h0001_FFFF, 0, dc);
    xfer(0, 1, B0 + 32'h08, 32'h104, 0, 0, dc);
    xfer(0, 0, B0 + 32'h04, 0, 32'h0001_FFFF, 0, dc);
    xfer(0, 0, B0 + 32'h08, 0, 32'h104, 0, dc);

    idle(2);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sdfirm_apb_slave.md
SDFIRM_APB_SLAVE -- requirements
Module: sdfirm_apb_slave

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0000, byte address of register 0; SHALL be 32-byte aligned.
REQ-002 Parameter NUM_REGS, 8, number of 32-bit registers decoded; legal range 3..16.
REQ-003 Parameter WAIT_STATES, 1, number of pready-low access cycles inserted before completion; legal range 0..15.
REQ-004 Parameter ID_VALUE, 32'h5344_4150, value returned by register 0.
REQ-005 pclk  input  1  single clock, all state updates on rising edge.
REQ-006 preset  input  1  reset, asynchronous assertion, active-high.
REQ-007 psel  input  1  slave select from initiator.
REQ-008 penable  input  1  access-phase indicator.
REQ-009 pwrite  input  1  1 = write, 0 = read.
REQ-010 paddr  input  32  byte address.
REQ-011 pwdata  input  32  write data.
REQ-012 pready  output  1  transfer completion.
REQ-013 prdata  output  32  read data, valid only while pready=1.
REQ-014 pslverr  output  1  error response, valid only while pready=1.

Function
REQ-015 Register map (offset from BASE_ADDR): 0x00 ID (RO, ID_VALUE); 0x04 STATUS (RO, [15:0] write count, [31:16] error count); 0x08..4*(NUM_REGS-1) scratch (RW, 32-bit).
REQ-016 State machine SHALL have states IDLE, WAIT, READY; reset state IDLE.
REQ-017 IDLE: psel=1 and penable=0 (setup phase) SHALL latch paddr, pwrite, pwdata and go to WAIT (WAIT_STATES>0, counter loaded with WAIT_STATES-1) or READY (WAIT_STATES=0); otherwise stay IDLE.
REQ-018 WAIT: pready=0; counter decrements each cycle; counter=0 moves to READY.
REQ-019 READY: pready=1 for exactly one cycle, then IDLE unconditionally.
REQ-020 Latency: pready SHALL rise in the (WAIT_STATES+1)th cycle after the setup cycle; the setup cycle issues no pready.
REQ-021 Back-to-back transfers: a setup phase in the cycle after READY SHALL be accepted with no gap cycle.
REQ-022 Decode error: address outside BASE_ADDR..BASE_ADDR+4*NUM_REGS-1, or paddr[1:0]!=0, SHALL give pslverr=1, prdata=0, no register change.
REQ-023 Write to ID or STATUS SHALL give pslverr=1, no register change.
REQ-024 Successful write SHALL update the target scratch register on the READY-cycle rising edge; the new value is readable by the next transfer.
REQ-025 Successful read SHALL drive the addressed register value on prdata during READY; STATUS reflects counts prior to the current transfer.
REQ-026 Write count SHALL increment on each successful write; error count SHALL increment on each pslverr completion; both saturate at 16'hFFFF.
REQ-027 Outside READY, pready=0, pslverr=0, prdata=32'h0.
REQ-028 Protocol abort: psel=0 or penable=0 while in WAIT or READY SHALL return to IDLE next cycle with no register write and no counter change.
REQ-029 Values latched at setup SHALL be used for the whole transfer; paddr/pwdata changes during the access phase SHALL be ignored.

Reset
REQ-030 preset=1 SHALL immediately force IDLE, pready=0, pslverr=0, prdata=0, counter=0, scratch registers=32'h0, both STATUS counts=0.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer with no write committed; after release the first setup phase is handled normally.

Verification
REQ-032 Read 0x00 after reset, WAIT_STATES=1 -> pready high in 2nd cycle after setup, prdata=32'h5344_4150, pslverr=0.
REQ-033 Write 0x08=32'hDEAD_BEEF then read 0x08 -> prdata=32'hDEAD_BEEF, STATUS read = 32'h0000_0001.
REQ-034 Write 0x00=32'h1, read 0x40 (NUM_REGS=8), read 0x0A -> each pslverr=1 with prdata=0; STATUS error count=3, ID unchanged.
REQ-035 WAIT_STATES=0, back-to-back writes 0x0C=1, 0x10=2 in consecutive setup/access pairs -> pready every 2nd cycle, both values read back.
REQ-036 Write 0x14=32'h55 with preset pulsed during WAIT -> outputs zero immediately, later read 0x14 = 32'h0, STATUS = 0.
REQ-037 16'hFFFF+2 successful writes -> STATUS[15:0] stays 16'hFFFF, no wrap to 0.
